// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  reset_sequencer_if
//  Reset source inputs and sequenced reset outputs of reset_sequencer.
//  Revision: 1.0
// ============================================================================
interface reset_sequencer_if #(
  parameter int NUM_OUT = 2
);
  logic               btn_n;
  logic               pll_locked;
  logic               sw_reset_req;
  logic [NUM_OUT-1:0] reset_out;
  logic               ready;
  logic [1:0]         state;
  logic [7:0]         reset_count;

  modport master (
    output btn_n, pll_locked, sw_reset_req,
    input  reset_out, ready, state, reset_count
  );

  modport slave (
    input  btn_n, pll_locked, sw_reset_req,
    output reset_out, ready, state, reset_count
  );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  reset_sequencer
//  Debounced/synchronised reset sources -> hold -> staggered domain release.
//  Revision: 1.0
// ============================================================================
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int NUM_OUT         = 2,
  parameter int STAGGER_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  reset_sequencer_if.slave bus
);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int REL_MAX = NUM_OUT * STAGGER_CYCLES;
  localparam int REL_W   = $clog2(REL_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_MAX - 1);

  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0] pll_sync_q;
  logic                   btn_s;
  logic                   pll_s;

  logic                   btn_db;
  logic [DB_W-1:0]        db_cnt;

  logic [1:0]             state_q;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [REL_W-1:0]       rel_cnt;
  logic [NUM_OUT-1:0]     reset_out_q;
  logic                   ready_q;
  logic [7:0]             count_q;

  logic                   fault;
  logic [NUM_OUT-1:0]     rel_hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_sync_q <= '0;
      pll_sync_q <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], bus.btn_n};
      pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign pll_s = pll_sync_q[SYNC_STAGES-1];

  // Reset value 0 means "pressed", so a released button must be debounced first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign fault = !btn_db || !pll_s || bus.sw_reset_req;

  // Bit i drops i*STAGGER_CYCLES edges after bit 0, which drops on RELEASE entry.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_release
    if (i == 0) begin : g_first
      assign rel_hit[i] = 1'b0;
    end else begin : g_later
      assign rel_hit[i] = (rel_cnt == REL_W'(i * STAGGER_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_ASSERT;
      hold_cnt    <= '0;
      rel_cnt     <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          reset_out_q <= '1;
          ready_q     <= 1'b0;
          hold_cnt    <= '0;
          rel_cnt     <= '0;
          if (!fault) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (fault) begin
            state_q     <= ST_ASSERT;
            reset_out_q <= '1;
            hold_cnt    <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_q        <= ST_RELEASE;
            reset_out_q[0] <= 1'b0;
            hold_cnt       <= '0;
            rel_cnt        <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (fault) begin
            state_q     <= ST_ASSERT;
            reset_out_q <= '1;
            rel_cnt     <= '0;
          end else begin
            reset_out_q <= reset_out_q & ~rel_hit;
            if (rel_cnt == REL_LAST) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              rel_cnt <= '0;
            end else begin
              rel_cnt <= rel_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (fault) begin
            state_q     <= ST_ASSERT;
            reset_out_q <= '1;
            ready_q     <= 1'b0;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
          end
        end
        default: begin
          state_q     <= ST_ASSERT;
          reset_out_q <= '1;
          ready_q     <= 1'b0;
          hold_cnt    <= '0;
          rel_cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.reset_out   = reset_out_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state_q;
  assign bus.reset_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_reset_sequencer
//  Scenario tasks plus randomized run against a time-in-state reference model.
//  Revision: 1.0
// ============================================================================
module tb_reset_sequencer;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int HOLD_CYCLES     = 8;
  localparam int NUM_OUT         = 3;
  localparam int STAGGER_CYCLES  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_OUT(NUM_OUT)) bus ();

  reset_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .NUM_OUT        (NUM_OUT),
    .STAGGER_CYCLES (STAGGER_CYCLES)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // {state, ready, reset_out, reset_count}
  logic [13:0] dut_o;
  assign dut_o = {bus.state, bus.ready, bus.reset_out, bus.reset_count};

  // Reference model: state plus cycles spent in it; outputs derived arithmetically.
  int m_state = 0;
  int m_t = 0;
  int m_cnt = 0;
  bit m_db = 1'b0;
  int m_run = 0;
  bit btn_q[$] = '{1'b0, 1'b0};
  bit pll_q[$] = '{1'b0, 1'b0};

  function automatic logic [13:0] m_out();
    logic [NUM_OUT-1:0] ro;
    ro = '1;
    if (m_state == 2) begin
      for (int i = 0; i < NUM_OUT; i++) ro[i] = (i * STAGGER_CYCLES > m_t);
    end else if (m_state == 3) begin
      ro = '0;
    end
    return {2'(m_state), (m_state == 3), ro, 8'(m_cnt)};
  endfunction

  task automatic tick();
    bit f;
    bit bs;
    bit ps;
    @(posedge clk);
    bs = btn_q[0];
    ps = pll_q[0];
    if (!reset_n) begin
      m_state = 0; m_t = 0; m_cnt = 0; m_db = 1'b0; m_run = 0;
      btn_q = {};
      pll_q = {};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_q.push_back(1'b0);
        pll_q.push_back(1'b0);
      end
    end else begin
      f = !m_db || !ps || bus.sw_reset_req;
      case (m_state)
        0: if (!f) begin m_state = 1; m_t = 0; end
        1: if (f) m_state = 0;
           else if (m_t == HOLD_CYCLES - 1) begin m_state = 2; m_t = 0; end
           else m_t++;
        2: if (f) m_state = 0;
           else if (m_t == NUM_OUT * STAGGER_CYCLES - 1) begin m_state = 3; m_t = 0; end
           else m_t++;
        default: if (f) begin m_state = 0; if (m_cnt < 255) m_cnt++; end
      endcase
      if (bs == m_db) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEBOUNCE_CYCLES) begin m_db = bs; m_run = 0; end
      end
      btn_q.push_back(bus.btn_n);
      void'(btn_q.pop_front());
      pll_q.push_back(bus.pll_locked);
      void'(pll_q.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.btn_n = 1'($urandom);
      bus.pll_locked = 1'($urandom);
      bus.sw_reset_req = 1'($urandom);
      tick();
      vectors++;
      if (dut_o !== {2'd0, 1'b0, 3'b111, 8'd0}) begin
        miscompares++;
        $display("FAIL reset_state: got %h expected %h", dut_o, {2'd0, 1'b0, 3'b111, 8'd0});
      end
    end
    bus.btn_n = 1'b1; bus.pll_locked = 1'b1; bus.sw_reset_req = 1'b0;
  endtask

  task automatic test_power_up();
    int k;
    int hold_len;
    reset_n = 1'b1;
    k = 0;
    while (bus.state == 2'd0 && k < 50) begin
      tick();
      k++;
      vectors++;
      if (dut_o !== m_out()) begin
        miscompares++;
        $display("FAIL power_up_model: got %h expected %h", dut_o, m_out());
      end
    end
    vectors++;
    if (k != 7) begin
      miscompares++;
      $display("FAIL power_up_assert_len: got %0d cycles expected 7", k);
    end
    hold_len = 1;
    while (bus.state == 2'd1 && hold_len < 50) begin tick(); hold_len++; end
    vectors++;
    if (hold_len != HOLD_CYCLES + 1 || dut_o !== {2'd2, 1'b0, 3'b110, 8'd0}) begin
      miscompares++;
      $display("FAIL hold_len: got %0d/%h expected %0d/%h", hold_len - 1, dut_o,
               HOLD_CYCLES, {2'd2, 1'b0, 3'b110, 8'd0});
    end
    tick();
    vectors++;
    if (bus.reset_out !== 3'b110) begin
      miscompares++;
      $display("FAIL release_t1: got %b expected 110", bus.reset_out);
    end
    tick();
    vectors++;
    if (bus.reset_out !== 3'b100 || dut_o !== m_out()) begin
      miscompares++;
      $display("FAIL release_t2: got %h expected %h", dut_o, m_out());
    end
    tick(); tick();
    vectors++;
    if (bus.reset_out !== 3'b000 || bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_t4: got %b/%b expected 000/0", bus.reset_out, bus.ready);
    end
    tick(); tick();
    vectors++;
    if (dut_o !== {2'd3, 1'b1, 3'b000, 8'd0}) begin
      miscompares++;
      $display("FAIL run_entry: got %h expected %h", dut_o, {2'd3, 1'b1, 3'b000, 8'd0});
    end
  endtask

  task automatic test_bounce();
    bus.btn_n = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    bus.btn_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (dut_o !== {2'd3, 1'b1, 3'b000, 8'd0} || dut_o !== m_out()) begin
        miscompares++;
        $display("FAIL short_bounce: got %h expected %h", dut_o, m_out());
      end
    end
    bus.btn_n = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    bus.btn_n = 1'b1;
    vectors++;
    if (bus.state !== 2'd3) begin
      miscompares++;
      $display("FAIL long_bounce_early: state=%0d expected 3", bus.state);
    end
    tick();
    vectors++;
    if (dut_o !== {2'd0, 1'b0, 3'b111, 8'd1} || dut_o !== m_out()) begin
      miscompares++;
      $display("FAIL long_bounce: got %h expected %h", dut_o, {2'd0, 1'b0, 3'b111, 8'd1});
    end
  endtask

  task automatic test_lock_loss();
    for (int k = 0; k < 100 && bus.reset_out != 3'b110; k++) tick();
    vectors++;
    if (bus.reset_out !== 3'b110 || bus.state !== 2'd2) begin
      miscompares++;
      $display("FAIL reach_release: got %h expected state 2 reset_out 110", dut_o);
    end
    bus.pll_locked = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (bus.state !== 2'd2 || dut_o !== m_out()) begin
        miscompares++;
        $display("FAIL lock_loss_sync: got %h expected %h", dut_o, m_out());
      end
    end
    tick();
    vectors++;
    if (dut_o !== {2'd0, 1'b0, 3'b111, 8'd1}) begin
      miscompares++;
      $display("FAIL lock_loss: got %h expected %h", dut_o, {2'd0, 1'b0, 3'b111, 8'd1});
    end
    bus.pll_locked = 1'b1;
  endtask

  task automatic test_sw_reset();
    for (int k = 0; k < 100 && bus.state != 2'd3; k++) tick();
    vectors++;
    if (bus.state !== 2'd3) begin
      miscompares++;
      $display("FAIL sw_wait_run: state=%0d expected 3", bus.state);
    end
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    vectors++;
    if (dut_o !== {2'd0, 1'b0, 3'b111, 8'd2} || dut_o !== m_out()) begin
      miscompares++;
      $display("FAIL sw_reset: got %h expected %h", dut_o, {2'd0, 1'b0, 3'b111, 8'd2});
    end
    for (int k = 0; k < 100 && bus.state != 2'd3; k++) tick();
    vectors++;
    if (dut_o !== {2'd3, 1'b1, 3'b000, 8'd2}) begin
      miscompares++;
      $display("FAIL sw_resequence: got %h expected %h", dut_o, {2'd3, 1'b1, 3'b000, 8'd2});
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 100 && bus.state != 2'd3; k++) tick();
      bus.sw_reset_req = 1'b1;
      tick();
      bus.sw_reset_req = 1'b0;
      vectors++;
      if (dut_o !== m_out()) begin
        miscompares++;
        $display("FAIL sat_step%0d: got %h expected %h", n, dut_o, m_out());
      end
    end
    vectors++;
    if (bus.reset_count !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation: got %0d expected 255", bus.reset_count);
    end
  endtask

  task automatic test_reset_in_run();
    for (int k = 0; k < 100 && bus.state != 2'd3; k++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    vectors++;
    if (dut_o !== {2'd0, 1'b0, 3'b111, 8'd0} || dut_o !== m_out()) begin
      miscompares++;
      $display("FAIL reset_in_run: got %h expected %h", dut_o, {2'd0, 1'b0, 3'b111, 8'd0});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 24) == 0) bus.btn_n = ~bus.btn_n;
      if (bus.pll_locked) bus.pll_locked = ($urandom_range(0, 79) != 0);
      else bus.pll_locked = ($urandom_range(0, 9) == 0);
      bus.sw_reset_req = ($urandom_range(0, 59) == 0);
      tick();
      vectors++;
      if (dut_o !== m_out()) begin
        miscompares++;
        $display("FAIL random_c%0d: got %h expected %h", k, dut_o, m_out());
      end
    end
    reset_n = 1'b1;
    bus.sw_reset_req = 1'b0;
  endtask

  initial begin
    bus.btn_n = 1'b1;
    bus.pll_locked = 1'b1;
    bus.sw_reset_req = 1'b0;
    test_reset();
    test_power_up();
    test_bounce();
    test_lock_loss();
    test_sw_reset();
    test_saturation();
    test_reset_in_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchroniser depth for btn_n and pll_locked; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 400000, consecutive stable cycles needed to accept a btn_n change; legal range 1..2^24.
REQ-003 Parameter HOLD_CYCLES, default 1024, reset hold time after all reset sources clear; legal range 1..2^20.
REQ-004 Parameter NUM_OUT, default 2, number of reset domains; legal range 1..8.
REQ-005 Parameter STAGGER_CYCLES, default 16, spacing between successive domain releases; legal range 1..256.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset_n  input  1  synchronous, active-low block reset.
REQ-008 btn_n  input  1  raw board pushbutton, asynchronous, low = pressed.
REQ-009 pll_locked  input  1  PLL lock flag, asynchronous, high = locked.
REQ-010 sw_reset_req  input  1  single-cycle software reset request, synchronous to clk.
REQ-011 reset_out  output  NUM_OUT  active-high per-domain resets; bit 0 released first.
REQ-012 ready  output  1  high only in RUN.
REQ-013 state  output  2  current FSM state: ASSERT=0, HOLD=1, RELEASE=2, RUN=3.
REQ-014 reset_count  output  8  saturating count of RUN->ASSERT transitions.

Function
REQ-015 btn_n and pll_locked SHALL each pass through a SYNC_STAGES flop chain before any use.
REQ-016 btn_db SHALL take the synchronised btn_n value only after it differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; the counter SHALL clear on any cycle where they match.
REQ-017 Fault SHALL be true when btn_db=0, synchronised pll_locked=0, or sw_reset_req=1.
REQ-018 ASSERT: all reset_out bits 1, counters cleared; SHALL move to HOLD on the first cycle with fault false.
REQ-019 HOLD: SHALL remain exactly HOLD_CYCLES cycles, then move to RELEASE.
REQ-020 RELEASE: reset_out[0] SHALL fall on the edge entering RELEASE; reset_out[i] SHALL fall exactly i*STAGGER_CYCLES cycles after reset_out[0]; once released, a bit SHALL stay low until ASSERT.
REQ-021 RELEASE SHALL move to RUN exactly STAGGER_CYCLES cycles after reset_out[NUM_OUT-1] falls; ready SHALL rise on the edge entering RUN.
REQ-022 A fault in HOLD, RELEASE or RUN SHALL cause ASSERT on the next edge, with all reset_out bits 1 and ready 0 on that same edge.
REQ-023 A fault in ASSERT SHALL keep the FSM in ASSERT; sw_reset_req in ASSERT SHALL have no further effect.
REQ-024 reset_count SHALL increment by 1 on each RUN->ASSERT transition and saturate at 255; it SHALL not count transitions from HOLD or RELEASE.
REQ-025 Counter widths SHALL be $clog2 of their maximum value plus 1; no counter SHALL wrap.
REQ-026 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 With reset_n=0 at an edge: state ASSERT, reset_out all 1, ready 0, reset_count 0, debounce and hold counters 0.
REQ-028 Reset values: synchroniser flops 0 and btn_db 0 (pressed); a stable high btn_n SHALL therefore be debounced before leaving ASSERT.
REQ-029 reset_n=0 in any state, including mid-RELEASE, SHALL override all other inputs on that edge.

Verification
Settings for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, NUM_OUT=3, STAGGER_CYCLES=2.
REQ-030 Power-up: reset_n released, btn_n=1, pll_locked=1 -> ASSERT until btn_db rises; HOLD 8 cycles; reset_out 3'b110, then 3'b100 2 cycles later, then 3'b000 2 cycles later; ready=1 2 cycles after that.
REQ-031 Bounce: btn_n low for 3 cycles during RUN -> no state change, reset_count stays 0; btn_n low for 6 cycles -> ASSERT, reset_count=1.
REQ-032 Lock loss mid-RELEASE: pll_locked=0 with reset_out=3'b110 -> 3 cycles later (2 sync + 1) reset_out=3'b111, state=0, reset_count unchanged.
REQ-033 sw_reset_req one-cycle pulse in RUN -> next edge: ready=0, reset_out=3'b111, reset_count +1; full sequence repeats automatically.
REQ-034 Saturation: 300 sw_reset_req cycles, each issued after RUN is reached -> reset_count=255.
REQ-035 reset_n=0 for 1 cycle in RUN -> state=0, reset_out=3'b111, reset_count=0 on that edge.
